// File: rtl/msrv32_ifetch.sv
// Instruction fetch stage: holds the fetch PC, issues pipelined AHB-Lite reads
// and buffers returned words in a 2-entry queue presented to decode.
module msrv32_ifetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] pc_mux_in,
  input  logic        redirect_in,
  input  logic        misaligned_instr_in,
  input  logic        ahb_ready_in,
  input  logic [31:0] ahb_rdata_in,
  input  logic        ahb_resp_in,
  output logic [31:0] pc_out,
  output logic [31:0] iaddr_out,
  output logic [1:0]  htrans_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic        fetch_err_out,
  output logic [31:0] fetch_err_pc_out
);
  localparam int unsigned XLEN = 32;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            dvalid_q, dvalid_d;
  logic            dkill_q, dkill_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic            stall_q, stall_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            kill_acc_q, kill_acc_d;
  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] q0_instr_q, q0_instr_d, q0_pc_q, q0_pc_d;
  logic [XLEN-1:0] q1_instr_q, q1_instr_d, q1_pc_q, q1_pc_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] err_pc_q, err_pc_d;

  logic       pop_c, issue_c, accept_c, complete_c, live_c, push_c, err_c;
  logic [2:0] occ_c;

  // A stalled address phase must keep NONSEQ/HADDR stable until HREADY.
  assign pop_c      = instr_valid_out & instr_ready_in;
  assign occ_c      = 3'(count_q) + 3'(dvalid_q);
  assign issue_c    = stall_q | ((state_q == S_RUN) && (occ_c < (3'd2 + 3'(pop_c))));
  assign accept_c   = issue_c & ahb_ready_in;
  assign complete_c = dvalid_q & ahb_ready_in;
  assign live_c     = complete_c & ~dkill_q & ~redirect_in;
  assign push_c     = live_c & ~ahb_resp_in;
  assign err_c      = live_c & ahb_resp_in;

  assign pc_out           = pc_q;
  assign iaddr_out        = {pc_q[XLEN-1:2], 2'b00};
  assign htrans_out       = issue_c ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign instr_valid_out  = (count_q != 2'd0);
  assign instr_out        = q0_instr_q;
  assign instr_pc_out     = q0_pc_q;
  assign fetch_err_out    = err_q;
  assign fetch_err_pc_out = err_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dvalid_d   = dvalid_q;
    dkill_d    = dkill_q;
    dpc_d      = dpc_q;
    stall_d    = issue_c & ~ahb_ready_in;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    kill_acc_d = kill_acc_q;
    count_d    = count_q;
    q0_instr_d = q0_instr_q;
    q0_pc_d    = q0_pc_q;
    q1_instr_d = q1_instr_q;
    q1_pc_d    = q1_pc_q;
    err_d      = err_c;
    err_pc_d   = err_pc_q;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (err_c) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase

    if (err_c) err_pc_d = dpc_q;

    // Address/data phase bookkeeping; a transfer accepted alongside an error is stale.
    if (accept_c) begin
      dvalid_d   = 1'b1;
      dpc_d      = pc_q;
      dkill_d    = kill_acc_q | redirect_in | err_c;
      pend_d     = 1'b0;
      kill_acc_d = 1'b0;
      if (pend_q)                pc_d = pend_pc_q;
      else if (state_q == S_RUN) pc_d = pc_mux_in;
    end else if (complete_c) begin
      dvalid_d = 1'b0;
      dkill_d  = 1'b0;
    end else if (redirect_in) begin
      dkill_d = dkill_q | dvalid_q;
    end

    // Redirects override sequential advance; a stalled address defers the target.
    if (redirect_in) begin
      state_d = misaligned_instr_in ? S_HALT : S_RUN;
      if (misaligned_instr_in) begin
        pc_d   = pc_q;
        pend_d = 1'b0;
        if (stall_d) kill_acc_d = 1'b1;
      end else if (stall_d) begin
        pend_d     = 1'b1;
        pend_pc_d  = pc_mux_in;
        kill_acc_d = 1'b1;
      end else begin
        pc_d = pc_mux_in;
      end
    end

    if (redirect_in) begin
      count_d = 2'd0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (count_q == 2'd0) begin
            q0_instr_d = ahb_rdata_in;
            q0_pc_d    = dpc_q;
          end else begin
            q1_instr_d = ahb_rdata_in;
            q1_pc_d    = dpc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          q0_instr_d = q1_instr_q;
          q0_pc_d    = q1_pc_q;
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            q0_instr_d = ahb_rdata_in;
            q0_pc_d    = dpc_q;
          end else begin
            q0_instr_d = q1_instr_q;
            q0_pc_d    = q1_pc_q;
            q1_instr_d = ahb_rdata_in;
            q1_pc_d    = dpc_q;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_BOOT;
      pc_q       <= BOOT_ADDRESS;
      dvalid_q   <= 1'b0;
      dkill_q    <= 1'b0;
      dpc_q      <= '0;
      stall_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      kill_acc_q <= 1'b0;
      count_q    <= 2'd0;
      q0_instr_q <= '0;
      q0_pc_q    <= '0;
      q1_instr_q <= '0;
      q1_pc_q    <= '0;
      err_q      <= 1'b0;
      err_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dvalid_q   <= dvalid_d;
      dkill_q    <= dkill_d;
      dpc_q      <= dpc_d;
      stall_q    <= stall_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      kill_acc_q <= kill_acc_d;
      count_q    <= count_d;
      q0_instr_q <= q0_instr_d;
      q0_pc_q    <= q0_pc_d;
      q1_instr_q <= q1_instr_d;
      q1_pc_q    <= q1_pc_d;
      err_q      <= err_d;
      err_pc_q   <= err_pc_d;
    end
  end

  // The issue rule guarantees a free slot for every returning word.
  a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(push_c && (count_q == 2'd2)))
    else $error("ifetch queue overflow");

endmodule

// File: tb/tb_msrv32_ifetch.sv
// Directed bench for msrv32_ifetch: AHB memory model, PC-mux model and an
// expected-instruction scoreboard checked whenever decode accepts a word.
module tb_msrv32_ifetch;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] pc_mux_in;
  logic        redirect_in;
  logic        misaligned_instr_in;
  logic        ahb_ready_in;
  logic [31:0] ahb_rdata_in;
  logic        ahb_resp_in;
  logic [31:0] pc_out;
  logic [31:0] iaddr_out;
  logic [1:0]  htrans_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic        fetch_err_out;
  logic [31:0] fetch_err_pc_out;

  logic [31:0] tgt;
  logic        err_en;
  logic [31:0] err_addr;
  logic        tb_dv;
  logic [31:0] tb_dpc;
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  msrv32_ifetch dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .pc_mux_in          (pc_mux_in),
    .redirect_in        (redirect_in),
    .misaligned_instr_in(misaligned_instr_in),
    .ahb_ready_in       (ahb_ready_in),
    .ahb_rdata_in       (ahb_rdata_in),
    .ahb_resp_in        (ahb_resp_in),
    .pc_out             (pc_out),
    .iaddr_out          (iaddr_out),
    .htrans_out         (htrans_out),
    .instr_out          (instr_out),
    .instr_pc_out       (instr_pc_out),
    .instr_valid_out    (instr_valid_out),
    .instr_ready_in     (instr_ready_in),
    .fetch_err_out      (fetch_err_out),
    .fetch_err_pc_out   (fetch_err_pc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // PC mux: sequential +4 unless redirecting.
  assign pc_mux_in = redirect_in ? tgt : pc_out + 32'd4;

  // Memory data phase tracking.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tb_dv  <= 1'b0;
      tb_dpc <= 32'h0;
    end else if (ahb_ready_in) begin
      tb_dv <= (htrans_out == NONSEQ);
      if (htrans_out == NONSEQ) tb_dpc <= iaddr_out;
    end
  end
  assign ahb_rdata_in = mem_word(tb_dpc);
  assign ahb_resp_in  = tb_dv && err_en && (tb_dpc == err_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    redirect_in = 1'b0;
    misaligned_instr_in = 1'b0;
    ahb_ready_in = 1'b1;
    instr_ready_in = 1'b0;
    err_en = 1'b0;
    settle();
    chk("async_rst_htrans", 32'(htrans_out), 32'(IDLE));
    chk("async_rst_valid", 32'(instr_valid_out), 32'd0);
    chk("async_rst_pc", pc_out, 32'h0);
    exp_q.delete();
    cyc();
    cyc();
  endtask

  // Scoreboard: every word accepted by decode must be the next expected one.
  always @(negedge clk_in) begin
    if (!rst_in && instr_valid_out && instr_ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr_pc", instr_pc_out, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc_out, e);
        chk("instr_data", instr_out, mem_word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    redirect_in = 1'b0;
    misaligned_instr_in = 1'b0;
    ahb_ready_in = 1'b1;
    instr_ready_in = 1'b0;
    tgt = 32'h0;
    err_en = 1'b0;
    err_addr = 32'h0;
    cyc();
    cyc();
    settle();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_iaddr", iaddr_out, 32'h0);
    chk("rst_htrans", 32'(htrans_out), 32'(IDLE));
    chk("rst_valid", 32'(instr_valid_out), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc_out, 32'h0);
    chk("rst_err", 32'(fetch_err_out), 32'd0);
    chk("rst_err_pc", fetch_err_pc_out, 32'h0);

    // Sequential fetch, then decode backpressure and drain.
    push_seq(32'h0, 40);
    rst_in = 1'b0;
    instr_ready_in = 1'b1;
    settle();
    chk("boot_idle", 32'(htrans_out), 32'(IDLE));
    for (int k = 0; k < 6; k++) begin
      cyc();
      settle();
      chk("seq_htrans", 32'(htrans_out), 32'(NONSEQ));
      chk("seq_haddr", iaddr_out, 32'(4 * k));
      chk("seq_valid", 32'(instr_valid_out), (k >= 2) ? 32'd1 : 32'd0);
      if (k == 2) chk("first_instr_pc", instr_pc_out, 32'h0);
    end
    for (int j = 0; j < 5; j++) begin
      cyc();
      if (j == 0) instr_ready_in = 1'b0;
      settle();
      chk("bp_htrans_idle", 32'(htrans_out), 32'(IDLE));
      chk("bp_valid", 32'(instr_valid_out), 32'd1);
      chk("bp_head_pc", instr_pc_out, 32'h10);
    end
    cyc();
    instr_ready_in = 1'b1;
    settle();
    chk("resume_htrans", 32'(htrans_out), 32'(NONSEQ));
    chk("resume_haddr", iaddr_out, 32'h18);
    for (int m = 1; m < 6; m++) begin
      cyc();
      settle();
      chk("resume_seq_haddr", iaddr_out, 32'(32'h18 + 4 * m));
    end

    // Redirect with a queued word and an outstanding data phase.
    cyc();
    do_reset();
    push_seq(32'h0, 16);
    rst_in = 1'b0;
    instr_ready_in = 1'b1;
    settle();
    cyc(); cyc(); cyc();
    settle();
    chk("rd_head0", instr_pc_out, 32'h0);
    cyc();
    instr_ready_in = 1'b0;
    redirect_in = 1'b1;
    tgt = 32'h100;
    settle();
    chk("rd_hold_idle", 32'(htrans_out), 32'(IDLE));
    chk("rd_head4", instr_pc_out, 32'h4);
    cyc();
    redirect_in = 1'b0;
    exp_q.delete();
    push_seq(32'h100, 16);
    instr_ready_in = 1'b1;
    settle();
    chk("rd_flush_valid", 32'(instr_valid_out), 32'd0);
    chk("rd_htrans", 32'(htrans_out), 32'(NONSEQ));
    chk("rd_haddr", iaddr_out, 32'h100);
    cyc();
    settle();
    chk("rd_valid_gap", 32'(instr_valid_out), 32'd0);
    chk("rd_haddr2", iaddr_out, 32'h104);
    cyc();
    settle();
    chk("rd_valid_first", 32'(instr_valid_out), 32'd1);
    chk("rd_first_pc", instr_pc_out, 32'h100);
    cyc(); cyc();

    // Redirect during a three-cycle HREADY stall on address 0x10.
    do_reset();
    push_seq(32'h0, 16);
    rst_in = 1'b0;
    instr_ready_in = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) cyc();
    ahb_ready_in = 1'b0;
    settle();
    chk("st_haddr_c6", iaddr_out, 32'h10);
    cyc();
    redirect_in = 1'b1;
    tgt = 32'h200;
    settle();
    chk("st_htrans_c7", 32'(htrans_out), 32'(NONSEQ));
    chk("st_haddr_c7", iaddr_out, 32'h10);
    cyc();
    redirect_in = 1'b0;
    exp_q.delete();
    push_seq(32'h200, 16);
    settle();
    chk("st_htrans_c8", 32'(htrans_out), 32'(NONSEQ));
    chk("st_haddr_c8", iaddr_out, 32'h10);
    cyc();
    ahb_ready_in = 1'b1;
    settle();
    chk("st_htrans_c9", 32'(htrans_out), 32'(NONSEQ));
    chk("st_haddr_c9", iaddr_out, 32'h10);
    cyc();
    settle();
    chk("st_haddr_target", iaddr_out, 32'h200);
    chk("st_valid_c10", 32'(instr_valid_out), 32'd0);
    cyc();
    settle();
    chk("st_valid_c11", 32'(instr_valid_out), 32'd0);
    chk("st_haddr_c11", iaddr_out, 32'h204);
    cyc();
    settle();
    chk("st_first_pc", instr_pc_out, 32'h200);
    cyc(); cyc();

    // Bus error on 0x20, halt, then restart by redirect to 0x80.
    do_reset();
    push_seq(32'h0, 16);
    err_en = 1'b1;
    err_addr = 32'h20;
    rst_in = 1'b0;
    instr_ready_in = 1'b1;
    settle();
    for (int k = 0; k < 9; k++) cyc();
    settle();
    chk("er_haddr", iaddr_out, 32'h20);
    cyc();
    instr_ready_in = 1'b0;
    settle();
    chk("er_idle_c11", 32'(htrans_out), 32'(IDLE));
    chk("er_no_pulse_yet", 32'(fetch_err_out), 32'd0);
    cyc();
    settle();
    chk("er_pulse", 32'(fetch_err_out), 32'd1);
    chk("er_pc", fetch_err_pc_out, 32'h20);
    chk("er_idle_c12", 32'(htrans_out), 32'(IDLE));
    cyc();
    settle();
    chk("er_pulse_end", 32'(fetch_err_out), 32'd0);
    chk("er_pc_held", fetch_err_pc_out, 32'h20);
    chk("er_idle_c13", 32'(htrans_out), 32'(IDLE));
    cyc();
    redirect_in = 1'b1;
    tgt = 32'h80;
    err_en = 1'b0;
    settle();
    chk("er_idle_c14", 32'(htrans_out), 32'(IDLE));
    cyc();
    redirect_in = 1'b0;
    exp_q.delete();
    push_seq(32'h80, 16);
    instr_ready_in = 1'b1;
    settle();
    chk("er_restart_htrans", 32'(htrans_out), 32'(NONSEQ));
    chk("er_restart_haddr", iaddr_out, 32'h80);
    chk("er_restart_valid", 32'(instr_valid_out), 32'd0);
    cyc(); cyc();
    settle();
    chk("er_first_pc", instr_pc_out, 32'h80);
    cyc(); cyc();

    // Misaligned redirect halts; trap redirect to 0x40 restarts.
    do_reset();
    push_seq(32'h0, 16);
    rst_in = 1'b0;
    instr_ready_in = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) cyc();
    redirect_in = 1'b1;
    misaligned_instr_in = 1'b1;
    tgt = 32'h302;
    settle();
    chk("ma_haddr_c6", iaddr_out, 32'h10);
    cyc();
    redirect_in = 1'b0;
    misaligned_instr_in = 1'b0;
    exp_q.delete();
    settle();
    chk("ma_idle_c7", 32'(htrans_out), 32'(IDLE));
    chk("ma_valid_c7", 32'(instr_valid_out), 32'd0);
    cyc();
    settle();
    chk("ma_idle_c8", 32'(htrans_out), 32'(IDLE));
    cyc();
    redirect_in = 1'b1;
    tgt = 32'h40;
    settle();
    chk("ma_idle_c9", 32'(htrans_out), 32'(IDLE));
    cyc();
    redirect_in = 1'b0;
    push_seq(32'h40, 16);
    settle();
    chk("ma_restart_htrans", 32'(htrans_out), 32'(NONSEQ));
    chk("ma_restart_haddr", iaddr_out, 32'h40);
    cyc(); cyc();
    settle();
    chk("ma_first_pc", instr_pc_out, 32'h40);
    cyc(); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
